// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage valid/ready pipeline register with
// bubble collapse, synchronous flush and an occupancy count.
// Stage 0 faces the upstream producer; stage DEPTH-1 drives out_data.
module elastic_pipe_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];

    // r[i]: stage i may load this edge; r[DEPTH] is the downstream ready.
    logic [DEPTH:0]   r;
    // Word offered to each stage by its upstream neighbour.
    logic [DEPTH-1:0] inc_v;
    logic [WIDTH-1:0] inc_d [DEPTH];
    logic [CW-1:0]    count_w;

    // Ready chain: a stage can load if it is empty or its own word moves on.
    always_comb begin
        logic acc;
        r        = '0;
        acc      = out_ready;
        r[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc  = !v_q[i] || acc;
            r[i] = acc;
        end
    end

    // Incoming word per stage: stage 0 sees the upstream port, others the stage behind.
    always_comb begin
        inc_v[0] = in_valid;
        inc_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            inc_v[i] = v_q[i-1];
            inc_d[i] = d_q[i-1];
        end
    end

    // Next-state per stage: load when ready, data only when the incoming word is valid.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        for (int i = 0; i < DEPTH; i++) begin
            v_d[i] = v_q[i];
            d_d[i] = d_q[i];
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (r[i]) begin
                v_d[i] = inc_v[i];
                if (inc_v[i]) begin
                    d_d[i] = inc_d[i];
                end
            end
        end
    end

    // Stage registers with asynchronous clear to empty / RESET_VAL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            // NOTE: data words are reset as well because out_data must read RESET_VAL while the chain is empty.
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= RESET_VAL;
            end
        end else begin
            // NOTE: state flops use non-blocking assignment so every stage samples the pre-edge values of its neighbours.
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    // Occupancy from registered valid bits only.
    always_comb begin
        count_w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_w = count_w + CW'(v_q[i]);
        end
    end

    assign in_ready  = r[0] && !flush;
    assign out_valid = v_q[DEPTH-1] && !flush;
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_w;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: directed vectors with literal expectations plus a
// slot-level model of the chain compared against the DUT every cycle.
module tb_elastic_pipe_reg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;

    int n_cmp = 0;
    int n_err = 0;

    elastic_pipe_reg #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VAL('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: words in arrival order, each with the slot it occupies (0..DEPTH-1).
    typedef struct {
        logic [WIDTH-1:0] data;
        int               pos;
    } ent_t;
    ent_t mq[$];

    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mq[0].pos == DEPTH - 1) && !flush;
    endfunction

    function automatic bit m_in_ready();
        return !flush && ((mq.size() < DEPTH) || out_ready);
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: departures first, then each word advances one slot if the slot ahead is free.
    always @(posedge clk or negedge rst) begin
        bit in_x;
        bit out_x;
        int lim;
        if (!rst || flush) begin
            mq.delete();
        end else begin
            in_x  = in_valid && m_in_ready();
            out_x = m_out_valid() && out_ready;
            if (out_x) void'(mq.pop_front());
            lim = DEPTH - 1;
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].pos < lim) mq[k].pos = mq[k].pos + 1;
                lim = mq[k].pos - 1;
            end
            if (in_x) mq.push_back('{data: in_data, pos: 0});
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        check("m_count", 64'(count), 64'(mq.size()));
        check("m_in_ready", 64'(in_ready), 64'(m_in_ready()));
        check("m_out_valid", 64'(out_valid), 64'(m_out_valid()));
        if (m_out_valid()) check("m_out_data", out_data, mq[0].data);
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step(2);

        // 1. reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        rst = 1'b1;
        step(1);
        check("idle_count", 64'(count), 64'd0);

        // 2. streaming 0x1..0x8
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = 64'(k);
            step(1);
            if (k < 4) begin
                check("stream_lat_valid", 64'(out_valid), 64'd0);
                check("stream_fill_count", 64'(count), 64'(k));
            end else begin
                check("stream_valid", 64'(out_valid), 64'd1);
                check("stream_data", out_data, 64'(k - 3));
                check("stream_count", 64'(count), 64'd4);
            end
        end
        in_valid = 1'b0;
        for (int k = 9; k <= 11; k++) begin
            step(1);
            check("drain_data", out_data, 64'(k - 3));
            check("drain_count", 64'(count), 64'(12 - k));
        end
        step(1);
        check("drain_empty", 64'(out_valid), 64'd0);

        // 3. stall fill
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 64'h A0 + 64'(k);
            #1;
            check("fill_in_ready", 64'(in_ready), 64'd1);
            step(1);
        end
        check("fill_count", 64'(count), 64'd4);
        in_data = 64'h A4;
        #1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        step(2);
        check("full_hold_count", 64'(count), 64'd4);
        check("full_head", out_data, 64'h A0);
        out_ready = 1'b1;
        #1;
        check("full_ready_chain", 64'(in_ready), 64'd1);
        step(1);
        check("swap_count", 64'(count), 64'd4);
        check("swap_data", out_data, 64'h A1);
        in_data = 64'h A5;
        step(1);
        check("swap2_data", out_data, 64'h A2);
        in_valid = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            step(1);
            check("stall_drain", out_data, 64'h A0 + 64'(k));
        end
        step(1);
        check("stall_empty", 64'(count), 64'd0);

        // 4. bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h 11;
        step(1);
        in_valid  = 1'b0;
        step(2);
        in_valid  = 1'b1;
        in_data   = 64'h 22;
        step(1);
        in_valid  = 1'b0;
        check("bub_count", 64'(count), 64'd2);
        step(3);
        check("bub_head", out_data, 64'h 11);
        check("bub_head_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step(1);
        check("bub_second_valid", 64'(out_valid), 64'd1);
        check("bub_second", out_data, 64'h 22);
        step(1);
        check("bub_empty", 64'(count), 64'd0);

        // 5. flush with count=3 and a word offered
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_data  = 64'h 30 + 64'(k);
            step(1);
        end
        in_valid = 1'b0;
        step(1);
        check("pre_flush_count", 64'(count), 64'd3);
        check("pre_flush_valid", 64'(out_valid), 64'd1);
        in_valid  = 1'b1;
        in_data   = 64'h 34;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        step(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_flush_count", 64'(count), 64'd0);
        check("post_flush_valid", 64'(out_valid), 64'd0);
        step(4);
        check("post_flush_idle", 64'(count), 64'd0);

        // 1b. asynchronous reset mid-stream with count=3
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_data  = 64'h 40 + 64'(k);
            step(1);
        end
        in_valid = 1'b0;
        step(1);
        check("pre_rst_count", 64'(count), 64'd3);
        rst = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", out_data, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step(1);
        check("after_rst_count", 64'(count), 64'd0);

        // 6. random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 127) == 0);
            step(1);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(8);
        check("final_empty", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
